// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encodings and a gate-free counter increment helper
package serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Ripple increment built from xor/and so the design never needs the + operator
    function automatic logic [31:0] inc32(input logic [31:0] x);
        logic [31:0] r;
        logic c;
        c = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[i] ^ c;
            c    = x[i] & c;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// serial_adder_full_adder: primitive two-input gate cells and a structural full adder
module _xor (
    output logic y,
    input  logic a,
    input  logic b
);
    assign y = a ^ b;
endmodule

module _and (
    output logic y,
    input  logic a,
    input  logic b
);
    assign y = a & b;
endmodule

module _or (
    output logic y,
    input  logic a,
    input  logic b
);
    assign y = a | b;
endmodule

module full_adder (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    logic w_p, w_g, w_t;

    _xor u_x0 (.y(w_p),  .a(a),   .b(b));
    _xor u_x1 (.y(s),    .a(w_p), .b(cin));
    _and u_a0 (.y(w_g),  .a(a),   .b(b));
    _and u_a1 (.y(w_t),  .a(cin), .b(w_p));
    _or  u_o0 (.y(cout), .a(w_g), .b(w_t));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with start/busy/done handshake
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_opa, r_opb, r_sum;
    logic             r_carry, r_cout;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_s, w_c;

    full_adder u_fa (
        .s    (w_s),
        .cout (w_c),
        .a    (r_opa[0]),
        .b    (r_opb[0]),
        .cin  (r_carry)
    );

    // New sum bit enters at the MSB while the register shifts right; counter steps by one
    always_comb begin
        w_sum_nxt            = r_sum >> 1;
        w_sum_nxt[WIDTH-1]   = w_s;
        w_cnt_nxt            = CW'(inc32(32'(r_cnt)));
    end

    // FSM, operand/sum shift registers, carry flop and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= RUN;
                    r_opa   <= a;
                    r_opb   <= b;
                    r_sum   <= '0;
                    r_cout  <= 1'b0;
                    r_carry <= 1'b0;
                    r_cnt   <= '0;
                end
                RUN: begin
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_c;
                    r_cnt   <= w_cnt_nxt;
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        r_cout  <= w_c;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
